// File: rtl/set_bit_iter_pkg.sv
// Shared types for the set-bit iterator: controller states and the
// state chosen when a new vector is loaded.
package set_bit_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        EMPTY = 2'd2
    } state_e;

    // A loaded vector either has bits to walk, owes one empty beat, or is dropped.
    function automatic state_e load_state(input logic nonzero, input logic emit_empty);
        state_e s;
        if (nonzero) begin
            s = ITER;
        end else if (emit_empty) begin
            s = EMPTY;
        end else begin
            s = IDLE;
        end
        return s;
    endfunction

endpackage

// File: rtl/set_bit_iter_chk.sv
// Run-time checks for set_bit_iter: beat stability under backpressure and
// consistency between the controller state and the mask contents.
module set_bit_iter_chk
    import set_bit_iter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 5,
    parameter int unsigned REM_WIDTH = 6
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 flush_i,
    input logic                 out_valid_i,
    input logic                 out_ready_i,
    input logic [CNT_WIDTH-1:0] out_idx_i,
    input logic                 out_last_i,
    input logic                 out_empty_i,
    input logic [REM_WIDTH-1:0] remaining_i,
    input state_e               state_i,
    input logic                 lzc_empty_i
);

    localparam int unsigned SNAP_W = CNT_WIDTH + REM_WIDTH + 2;

    logic              hold_r;
    logic [SNAP_W-1:0] snap_r;
    logic [SNAP_W-1:0] snap_s;

    assign snap_s = {out_idx_i, out_last_i, out_empty_i, remaining_i};

    // A stalled beat must reappear unchanged on the following cycle.
    always_ff @(posedge clk_i) begin
        hold_r <= rst_ni & out_valid_i & ~out_ready_i & ~flush_i;
        snap_r <= snap_s;
        assert (WIDTH >= 32'd1) else $error("set_bit_iter: WIDTH must be at least 1");
        if (rst_ni) begin
            if (hold_r) begin
                assert (out_valid_i && (snap_s == snap_r))
                    else $error("set_bit_iter: beat changed while stalled");
            end
            assert (!out_valid_i || (state_i != IDLE))
                else $error("set_bit_iter: valid beat in IDLE");
            assert ((state_i == ITER) == !lzc_empty_i)
                else $error("set_bit_iter: mask contents disagree with state");
        end
    end

endmodule

// File: rtl/set_bit_iter_lzc.sv
// Leading/trailing zero counter: MODE=0 counts zeros from the LSB,
// MODE=1 counts zeros from the MSB. Count is 0 when the input is all zero.
module set_bit_iter_lzc #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = $clog2(WIDTH) + 32'(WIDTH == 32'd1)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    logic [WIDTH-1:0] ord_s;
    logic [WIDTH-1:0] sh_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ord
        assign ord_s[g] = MODE ? in_i[WIDTH-1-g] : in_i[g];
    end

    // Walk from the far end down so the lowest ordered set position wins.
    always_comb begin
        cnt_o = {CNT_WIDTH{1'b0}};
        sh_s  = {WIDTH{1'b0}};
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            sh_s  = ord_s >> i;
            cnt_o = sh_s[0] ? CNT_WIDTH'(i) : cnt_o;
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/set_bit_iter.sv
// Set-bit iterator: accepts a WIDTH-bit vector and emits the index of each
// set bit, one per cycle, LSB-first or MSB-first, with last/remaining info.
module set_bit_iter
    import set_bit_iter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          MODE       = 1'b0,
    parameter bit          EMIT_EMPTY = 1'b1,
    parameter int unsigned CNT_WIDTH  = $clog2(WIDTH) + 32'(WIDTH == 32'd1),
    parameter int unsigned REM_WIDTH  = $clog2(WIDTH + 32'd1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] out_idx_o,
    output logic                 out_last_o,
    output logic                 out_empty_o,
    output logic [REM_WIDTH-1:0] remaining_o,
    output logic                 busy_o
);

    state_e               state_r;
    logic [WIDTH-1:0]     mask_r;
    logic [CNT_WIDTH-1:0] zcnt_s;
    logic [CNT_WIDTH-1:0] idx_s;
    logic                 lzc_empty_s;
    logic [REM_WIDTH-1:0] pop_s;
    logic [WIDTH-1:0]     pop_sh_s;
    logic                 iter_s;
    logic                 empty_st_s;
    logic                 fire_s;
    logic                 accept_s;

    set_bit_iter_lzc #(
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lzc (
        .in_i    (mask_r),
        .cnt_o   (zcnt_s),
        .empty_o (lzc_empty_s)
    );

    // A leading-zero count is turned back into an absolute bit index.
    always_comb begin
        if (MODE) begin
            idx_s = CNT_WIDTH'(WIDTH - 32'd1 - 32'(zcnt_s));
        end else begin
            idx_s = zcnt_s;
        end
    end

    // Population count of the bits still pending in the mask.
    always_comb begin
        pop_s    = {REM_WIDTH{1'b0}};
        pop_sh_s = {WIDTH{1'b0}};
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop_sh_s = mask_r >> i;
            pop_s    = pop_s + REM_WIDTH'(pop_sh_s[0]);
        end
    end

    // Everything visible is forced quiet while reset is held.
    assign iter_s      = rst_ni & (state_r == ITER);
    assign empty_st_s  = rst_ni & (state_r == EMPTY);
    assign out_valid_o = iter_s | empty_st_s;
    assign out_idx_o   = iter_s ? idx_s : {CNT_WIDTH{1'b0}};
    assign out_last_o  = empty_st_s | (iter_s & (pop_s == REM_WIDTH'(1)));
    assign out_empty_o = empty_st_s;
    assign remaining_o = iter_s ? pop_s : {REM_WIDTH{1'b0}};
    assign busy_o      = rst_ni & (state_r != IDLE);

    // Taking a new vector during the final beat avoids a bubble between vectors.
    assign fire_s     = out_valid_o & out_ready_i;
    assign in_ready_o = rst_ni & ~flush_i & ((state_r == IDLE) | (fire_s & out_last_o));
    assign accept_s   = in_valid_i & in_ready_o;

    // Controller state and mask; flush outranks both handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            mask_r  <= {WIDTH{1'b0}};
        end else if (flush_i) begin
            state_r <= IDLE;
            mask_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            state_r <= load_state(|in_data_i, EMIT_EMPTY);
            mask_r  <= in_data_i;
        end else if (fire_s) begin
            if (out_last_o) begin
                state_r <= IDLE;
                mask_r  <= {WIDTH{1'b0}};
            end else begin
                mask_r  <= mask_r & ~(WIDTH'(1'b1) << idx_s);
            end
        end
    end

    set_bit_iter_chk #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .REM_WIDTH (REM_WIDTH)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .out_valid_i (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_idx_i   (out_idx_o),
        .out_last_i  (out_last_o),
        .out_empty_i (out_empty_o),
        .remaining_i (remaining_o),
        .state_i     (state_r),
        .lzc_empty_i (lzc_empty_s)
    );

endmodule

// File: tb/tb_set_bit_iter.sv
// Bench for set_bit_iter: three instances (8-bit LSB-first, 8-bit MSB-first
// without empty beats, 1-bit) share stimulus and are checked against a queue model.
module tb_set_bit_iter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic [2:0] in_ready_a, out_valid_a, last_a, empty_a, busy_a;
    logic [2:0] idx_a [3];
    logic [3:0] rem_a [3];
    logic       w1_idx, w1_rem;

    int n_pass  = 0;
    int n_total = 0;

    int mode_m [3] = '{0, 1, 1};
    int emit_m [3] = '{1, 0, 1};
    int w_m    [3] = '{8, 8, 1};
    int mq [3][$];
    bit mempty [3];

    always #5 clk = ~clk;

    set_bit_iter #(.WIDTH(8), .MODE(1'b0), .EMIT_EMPTY(1'b1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a[0]), .in_data_i(in_data), .out_valid_o(out_valid_a[0]),
        .out_ready_i(out_ready), .out_idx_o(idx_a[0]), .out_last_o(last_a[0]),
        .out_empty_o(empty_a[0]), .remaining_o(rem_a[0]), .busy_o(busy_a[0]));

    set_bit_iter #(.WIDTH(8), .MODE(1'b1), .EMIT_EMPTY(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a[1]), .in_data_i(in_data), .out_valid_o(out_valid_a[1]),
        .out_ready_i(out_ready), .out_idx_o(idx_a[1]), .out_last_o(last_a[1]),
        .out_empty_o(empty_a[1]), .remaining_o(rem_a[1]), .busy_o(busy_a[1]));

    set_bit_iter #(.WIDTH(1), .MODE(1'b1), .EMIT_EMPTY(1'b1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a[2]), .in_data_i(in_data[0]), .out_valid_o(out_valid_a[2]),
        .out_ready_i(out_ready), .out_idx_o(w1_idx), .out_last_o(last_a[2]),
        .out_empty_o(empty_a[2]), .remaining_o(w1_rem), .busy_o(busy_a[2]));

    assign idx_a[2] = {2'b00, w1_idx};
    assign rem_a[2] = {3'b000, w1_rem};

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d", name, k, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_pending(int k);
        return (mq[k].size() > 0) || mempty[k];
    endfunction

    function automatic bit m_valid(int k);
        return rst_n && m_pending(k);
    endfunction

    function automatic bit m_last(int k);
        return m_valid(k) && (mempty[k] || mq[k].size() == 1);
    endfunction

    function automatic bit m_ready(int k);
        return rst_n && !flush && (!m_pending(k) || (out_ready && m_last(k)));
    endfunction

    task automatic load_vec(int k, logic [7:0] d);
        mq[k].delete();
        mempty[k] = 1'b0;
        if (mode_m[k] == 0) begin
            for (int i = 0; i < w_m[k]; i++) if (((d >> i) & 8'd1) != 8'd0) mq[k].push_back(i);
        end else begin
            for (int i = w_m[k] - 1; i >= 0; i--) if (((d >> i) & 8'd1) != 8'd0) mq[k].push_back(i);
        end
        if (mq[k].size() == 0) mempty[k] = (emit_m[k] != 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) mempty[k] = 1'b0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                bit fire, acc;
                fire = m_valid(k) && out_ready;
                acc  = in_valid && m_ready(k);
                if (!rst_n || flush) begin
                    mq[k].delete();
                    mempty[k] = 1'b0;
                end else begin
                    if (fire) begin
                        if (mempty[k]) mempty[k] = 1'b0;
                        else void'(mq[k].pop_front());
                    end
                    if (acc) load_vec(k, in_data);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("in_ready", k, int'(in_ready_a[k]), int'(m_ready(k)));
                chk("out_valid", k, int'(out_valid_a[k]), int'(m_valid(k)));
                chk("busy", k, int'(busy_a[k]), int'(m_valid(k)));
                if (m_valid(k)) begin
                    chk("idx", k, int'(idx_a[k]), mempty[k] ? 0 : mq[k][0]);
                    chk("last", k, int'(last_a[k]), int'(m_last(k)));
                    chk("empty", k, int'(empty_a[k]), int'(mempty[k]));
                    chk("remaining", k, int'(rem_a[k]), mq[k].size());
                end else begin
                    chk("remaining_idle", k, int'(rem_a[k]), 0);
                    chk("last_idle", k, int'(last_a[k]), 0);
                    chk("empty_idle", k, int'(empty_a[k]), 0);
                    if (!rst_n) chk("idx_reset", k, int'(idx_a[k]), 0);
                end
            end
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic beat(input string name, input int k, input int idx, input int rem, input int last);
        chk({name, "_valid"}, k, int'(out_valid_a[k]), 1);
        chk({name, "_idx"}, k, int'(idx_a[k]), idx);
        chk({name, "_rem"}, k, int'(rem_a[k]), rem);
        chk({name, "_last"}, k, int'(last_a[k]), last);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        cyc(); #2;
        chk("reset_ready", 0, int'(in_ready_a[0]), 0);
        chk("reset_valid", 0, int'(out_valid_a[0]), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        idle(2);

        // Basic walk: 8'b1010_0100
        in_valid = 1'b1; in_data = 8'hA4; #2;
        chk("accept_ready", 0, int'(in_ready_a[0]), 1);
        cyc(); in_valid = 1'b0; #2;
        beat("b1", 0, 2, 3, 0); beat("b1", 1, 7, 3, 0);
        cyc(); #2;
        beat("b2", 0, 5, 2, 0); beat("b2", 1, 5, 2, 0);
        cyc(); #2;
        beat("b3", 0, 7, 1, 1); beat("b3", 1, 2, 1, 1);
        cyc(); #2;
        chk("done_busy", 0, int'(busy_a[0]), 0);
        chk("done_busy", 1, int'(busy_a[1]), 0);
        idle(2);

        // Backpressure on the second beat
        in_valid = 1'b1; in_data = 8'hA4;
        cyc(); in_valid = 1'b0;
        cyc(); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2; beat("stall", 0, 5, 2, 0); beat("stall", 1, 5, 2, 0);
            cyc();
        end
        out_ready = 1'b1; #2;
        beat("release", 0, 5, 2, 0);
        cyc(); #2;
        beat("resume", 0, 7, 1, 1); beat("resume", 1, 2, 1, 1);
        idle(3);

        // All-zero vector
        in_valid = 1'b1; in_data = 8'h00;
        cyc(); in_valid = 1'b0; #2;
        beat("zero", 0, 0, 0, 1);
        chk("zero_empty", 0, int'(empty_a[0]), 1);
        chk("zero_valid", 1, int'(out_valid_a[1]), 0);
        chk("zero_ready", 1, int'(in_ready_a[1]), 1);
        idle(2);

        // Single-bit vector on the 1-bit instance
        in_valid = 1'b1; in_data = 8'h01;
        cyc(); in_valid = 1'b0; #2;
        beat("w1", 2, 0, 1, 1);
        chk("w1_empty", 2, int'(empty_a[2]), 0);
        idle(3);

        // Back-to-back vectors without a bubble
        in_valid = 1'b1; in_data = 8'h81;
        cyc(); in_valid = 1'b0; #2;
        beat("bb1", 0, 0, 2, 0); beat("bb1", 1, 7, 2, 0);
        cyc(); in_valid = 1'b1; in_data = 8'h10; #2;
        beat("bb2", 0, 7, 1, 1);
        chk("bb2_ready", 0, int'(in_ready_a[0]), 1);
        chk("bb2_ready", 1, int'(in_ready_a[1]), 1);
        cyc(); in_valid = 1'b0; #2;
        beat("bb3", 0, 4, 1, 1); beat("bb3", 1, 4, 1, 1);
        idle(3);

        // Flush during the idx-5 beat with a competing input
        in_valid = 1'b1; in_data = 8'hA4;
        cyc(); in_valid = 1'b0;
        cyc(); flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF; #2;
        chk("flush_ready", 0, int'(in_ready_a[0]), 0);
        chk("flush_ready", 1, int'(in_ready_a[1]), 0);
        cyc(); flush = 1'b0; in_valid = 1'b0; #2;
        chk("flush_valid", 0, int'(out_valid_a[0]), 0);
        chk("flush_rem", 0, int'(rem_a[0]), 0);
        idle(2);

        // Same with reset
        in_valid = 1'b1; in_data = 8'hA4;
        cyc(); in_valid = 1'b0;
        cyc(); rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; #2;
        chk("rst_ready", 0, int'(in_ready_a[0]), 0);
        chk("rst_valid", 0, int'(out_valid_a[0]), 0);
        cyc(); rst_n = 1'b1; in_valid = 1'b0; #2;
        chk("rst_after_valid", 0, int'(out_valid_a[0]), 0);
        chk("rst_after_rem", 0, int'(rem_a[0]), 0);
        idle(2);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = 8'h00;
                1:       in_data = 8'(8'd1 << $urandom_range(0, 7));
                default: in_data = 8'($urandom);
            endcase
        end
        cyc();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/set_bit_iter.md
Name: set_bit_iter

Overview:
Sequential successor to the combinational leading/trailing zero counter. It accepts a WIDTH-bit vector over a valid/ready handshake. It then emits the index of every set bit, one per cycle, in LSB-first or MSB-first order, with a last flag and a remaining-count. Typical uses are arbiter grant walking, interrupt/request scanning and sparse-mask expansion in front of per-index consumers.

Parameters:
- WIDTH, 32, input vector width (>=1).
- MODE, 1'b0, scan order: 0 = LSB-first (trailing), 1 = MSB-first (leading).
- EMIT_EMPTY, 1'b1, 1 = an all-zero vector produces one beat flagged empty; 0 = it is silently consumed.
- CNT_WIDTH, $clog2(WIDTH)+(WIDTH==1), dependent parameter, do not override.
- REM_WIDTH, $clog2(WIDTH+1), dependent parameter, do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous abort of the current vector.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  input vector accepted when valid&ready.
- in_data_i  in  WIDTH  vector to iterate.
- out_valid_o  out  1  index beat valid.
- out_ready_i  in  1  downstream accepts beat.
- out_idx_o  out  CNT_WIDTH  bit index; MSB-first still reports absolute index (bit 7 = 7).
- out_last_o  out  1  final beat of this vector.
- out_empty_o  out  1  beat represents an all-zero vector.
- remaining_o  out  REM_WIDTH  set bits still pending, including the current beat.
- busy_o  out  1  state != IDLE.

Behaviour:
- State register: IDLE, ITER, EMPTY. Mask register: WIDTH bits.
- Reset (rst_ni=0 at a clock edge):
  - Next state is IDLE, mask = 0.
  - While rst_ni=0, in_ready_o=0 and out_valid_o=0.
  - All other outputs are 0.
  - Reset mid-iteration drops the vector with no further beats.
- in_ready_o = rst_ni & ~flush_i & (IDLE | (out_valid_o & out_ready_i & out_last_o)). This is combinational from out_ready_i and gives back-to-back vectors with no bubble.
- Accept (in_valid_i & in_ready_o):
  - mask <= in_data_i.
  - Nonzero data: next state ITER.
  - Zero data with EMIT_EMPTY=1: next state EMPTY.
  - Zero data with EMIT_EMPTY=0: next state IDLE.
- Latency: first beat is visible the cycle after accept. All outputs are driven from registers plus the find-first logic on the mask; there is no in_data_i→out path.
- ITER:
  - out_valid_o=1.
  - out_idx_o = first set bit of the mask per MODE.
  - out_last_o = (popcount(mask)==1).
  - remaining_o = popcount(mask).
  - On handshake: clear bit out_idx_o in the mask. If last, go to IDLE, or load a new vector if one is accepted the same cycle. Throughput is 1 index/cycle.
- EMPTY:
  - out_valid_o=1, out_idx_o=0, out_empty_o=1, out_last_o=1, remaining_o=0.
  - On handshake: IDLE, or accept a new vector the same cycle.
- Backpressure: while out_valid_o & ~out_ready_i, all out_* and remaining_o hold stable. out_valid_o never drops without a handshake, except on flush or reset.
- flush_i: next state IDLE, mask=0, out_valid_o=0 from the next cycle. flush has priority over both handshakes in the same cycle; a beat presented during a flush cycle does not count as transferred.
- IDLE: out_valid_o=0, remaining_o=0, busy_o=0.
- WIDTH=1: out_idx_o is always 0; a vector 1'b1 yields a single beat with last=1.

Decomposition:
- Package set_bit_iter_pkg holds state_e {IDLE, ITER, EMPTY}.
- One sub-module: instantiate the existing lzc cell (WIDTH, MODE) on the mask register to produce out_idx_o. Its empty output cross-checks state in assertions.
- The popcount is an inline reduction in this module.
- Assertions (translate_off):
  - Output stability under backpressure.
  - out_valid_o implies state != IDLE.
  - WIDTH>=1.

Test Plan:
- WIDTH=8, MODE=0, in 8'b1010_0100, out_ready=1 → beats idx 2,5,7 on cycles t+1..t+3; remaining 3,2,1; last only on idx 7; busy low at t+4.
- Same vector, MODE=1 → idx 7,5,2; remaining 3,2,1.
- Backpressure: out_ready_i low 4 cycles at the second beat → idx 5, remaining 2, last 0 held stable; resumes with idx 7 after release.
- 8'h00 with EMIT_EMPTY=1 → one beat idx 0, empty=1, last=1, remaining 0. With EMIT_EMPTY=0 → no beat, in_ready_o high the next cycle.
- Back-to-back: 8'h81 then 8'h10 offered during the last beat (idx 7) → accepted that cycle; idx 4 appears the next cycle with no bubble.
- Flush during the idx-5 beat with in_valid_i=1 in the same cycle → no accept, out_valid_o=0 next cycle, remaining 0. Repeat with rst_ni=0 instead → same, and in_ready_o=0 during reset.
